imem_boot_loader: RTL



---
 rtl/cpu_pkg.sv | 15 +
 rtl/imem_word_assembler.sv | 43 ++++
 rtl/imem_boot_loader.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory boot path: state encoding,
// NOP instruction and memory depth.
package cpu_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INST   = 32'h0;
  localparam int          IMEM_DEPTH = 128;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid pulses for one
// cycle after the handshake of every 4th byte.
module imem_word_assembler (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_cnt   <= 2'd0;
      asm_q      <= 24'h0;
      word_valid <= 1'b0;
      word       <= 32'h0;
    end else if (clr) begin
      // word is left as-is so the last written value stays visible
      byte_cnt   <= 2'd0;
      asm_q      <= 24'h0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        if (byte_cnt == 2'd3) begin
          word       <= {asm_q, byte_data};
          word_valid <= 1'b1;
          byte_cnt   <= 2'd0;
          asm_q      <= 24'h0;
        end else begin
          asm_q    <= {asm_q[15:0], byte_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Sequences the instruction memory between byte-stream loading and CPU
// execution; holds the CPU in reset and gates fetches to NOP when not running.
module imem_boot_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH     = IMEM_DEPTH,
  parameter int ADDR_W    = 7,
  parameter int BOOT_HOLD = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  // Byte stream: a byte transfers on any cycle where rx_valid && rx_ready.
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       fetch_addr,
  input  logic [31:0]       mem_inst,
  output logic [31:0]       fetch_inst,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum,
  output logic [1:0]        dbg_state
);

  localparam state_t RESET_STATE = (BOOT_HOLD != 0) ? HOLD : RUN;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] word_idx;
  logic              accept, byte_fire, word_valid, last_word;
  logic [31:0]       word;

  assign accept    = load_start && (state_q != LOAD);
  assign byte_fire = rx_valid && rx_ready;
  assign last_word = word_valid && ({1'b0, word_idx} == (len_q - 1'b1));

  imem_word_assembler u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (accept),
    .byte_valid (byte_fire),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rx_ready  = (state_q == LOAD);
    busy      = (state_q == LOAD);
    err       = (state_q == ERR);
    dbg_state = state_q;
    if (accept) begin
      if (load_len == '0)                          state_d = RUN;
      else if (load_len > (ADDR_W + 1)'(DEPTH))   state_d = ERR;
      else                                         state_d = LOAD;
    end else if ((state_q == LOAD) && last_word) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cpu_rstn <= (RESET_STATE == RUN);
      done     <= 1'b0;
      len_q    <= '0;
      word_idx <= '0;
      checksum <= 32'h0;
    end else begin
      cpu_rstn <= (state_d == RUN);
      done     <= (accept && (load_len == '0)) || ((state_q == LOAD) && last_word);
      if (accept) begin
        len_q    <= load_len;
        word_idx <= '0;
        checksum <= 32'h0;
      end else if (word_valid) begin
        checksum <= checksum ^ word;
        // Stop at the final word so word_idx never runs past DEPTH-1
        if (!last_word) word_idx <= word_idx + 1'b1;
      end
    end
  end

  assign mem_we    = word_valid;
  assign mem_waddr = word_idx;
  assign mem_wdata = word;

  // Byte address below DEPTH*4 is the same test as word index below DEPTH
  assign fetch_inst = ((state_q == RUN) && (fetch_addr < 32'(DEPTH * 4)))
                      ? mem_inst : NOP_INST;

endmodule
